// File: rtl/ram_ctrl.sv
// Single-port synchronous RAM with req/ready handshake, pipelined reads, and a clear sequencer that runs after reset.
// Ports: clock, reset_n, req/we/address/dataIn in; ready, dataOut/dataValid, busy, overrun, ledState out.
module ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int READ_LATENCY = 1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic                  busy,
  output logic                  overrun,
  output logic [2:0]            ledState
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH-1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH:0]   clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [READ_LATENCY-1:0] pipe_v;
  logic [DATA_WIDTH-1:0]   pipe_d [READ_LATENCY];

  logic accept;
  logic rd;
  logic wr;

  // ready is gated by reset_n so it is low while reset is held,
  // even when the reset state is IDLE.
  assign ready  = reset_n & (state_q == IDLE);
  assign busy   = (state_q == CLEAR);
  assign accept = req & ready;
  assign rd     = accept & ~we;
  assign wr     = accept & we;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: if (clr_cnt == LAST) state_d = IDLE;
      IDLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      if (busy) clr_cnt <= clr_cnt + 1'b1;
      if (req & ~ready) overrun <= 1'b1;
    end
  end

  // No reset on the array; contents survive reset unless cleared.
  always_ff @(posedge clock) begin
    if (busy & reset_n)
      mem[clr_cnt[ADDR_WIDTH-1:0]] <= INIT_VALUE;
    else if (wr)
      mem[address] <= dataIn;
  end

  // Stage data only loads on a read, so the last stage holds the
  // most recent read result between strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= rd;
      if (rd) pipe_d[0] <= mem[address];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign dataValid = pipe_v[READ_LATENCY-1];
  assign dataOut   = pipe_d[READ_LATENCY-1];
  assign ledState  = {overrun, busy, dataValid};

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Parametrised single-port synchronous RAM for the simple processor, replacing the fixed 16x8 data memory.
- Adds a req/ready handshake, configurable read latency with a data-valid strobe, and a hardware clear sequencer that fills memory after reset.
- Adds a sticky overrun flag and a 3-bit LED status output.
- Sits between the processor datapath (address/data/control) and the board LEDs.

Parameters:
DATA_WIDTH, 8, width of each memory word
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words
READ_LATENCY, 1, cycles from accepted read to dataValid; legal 1..3
CLEAR_ON_RESET, 1, 1 = run clear sequence after reset, 0 = go straight to IDLE
INIT_VALUE, 0, word written to every location during clear

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
req  input  1  access request, sampled on clock
we  input  1  1 = write, 0 = read; meaningful only with req
address  input  ADDR_WIDTH  word address
dataIn  input  DATA_WIDTH  write data
ready  output  1  block accepts a request this cycle
dataOut  output  DATA_WIDTH  read data, valid when dataValid=1
dataValid  output  1  one-cycle strobe marking dataOut valid
busy  output  1  clear sequence in progress
overrun  output  1  sticky: a request arrived while ready=0
ledState  output  3  status LEDs: {overrun, busy, dataValid}

Behaviour:
Reset values (reset_n=0, asynchronous):
- dataOut=0, dataValid=0, overrun=0, read pipeline valid bits=0, clear counter=0.
- State=CLEAR if CLEAR_ON_RESET=1, else IDLE.
- ready=0 while reset_n=0.
- Memory array is not reset asynchronously; contents persist unless cleared.

States:
- CLEAR: each cycle writes INIT_VALUE to mem[clrCnt], then clrCnt increments.
  - Exit to IDLE after the cycle writing address DEPTH-1, i.e. exactly DEPTH cycles after reset release.
  - busy=1, ready=0 throughout.
- IDLE: ready=1, busy=0.
  - Accepted access = req & ready.
  - Write (we=1): mem[address] <= dataIn at that edge; no dataValid produced.
  - Read (we=0): array read registered, then shifted through READ_LATENCY-1 extra stages.
  - dataOut/dataValid update READ_LATENCY edges after the accepting edge.
  - One access per cycle; back-to-back reads are fully pipelined, one result per cycle.
- ready is combinational from state only; never depends on req.

dataOut/dataValid:
- dataValid high exactly one cycle per accepted read.
- dataOut holds its last read value when dataValid=0; it is never overwritten by writes.

Read-after-write: a read accepted in the cycle after a write to the same address returns the new data. Read and write cannot coincide in the same cycle (single port, we selects).

Overrun:
- Set when req=1 and ready=0 at a clock edge; that request is dropped with no memory change and no dataValid.
- Cleared only by reset_n.

Reset mid-operation:
- Aborts the clear sequence and flushes in-flight reads; no dataValid is emitted for them.
- Clear restarts from address 0 after release.
- Writes already committed before the reset remain unless cleared.

Address wrap: clrCnt is ADDR_WIDTH+1 bits so the DEPTH-1 terminal is detected without wrap ambiguity. The processor address has no wrap handling; full range is valid.

ledState = {overrun, busy, dataValid}, registered outputs, no extra latency.

Test Plan:
1. Reset release with defaults: busy=1, ready=0 for exactly 16 cycles, then ready=1; a read of every address 0..15 returns 8'h00 with one dataValid strobe each, 1 cycle after acceptance.
2. Write 8'hAA to addr 0 and 8'h0F to addr 1, then back-to-back reads of 1,0,1: dataOut sequence 0F, AA, 0F on three consecutive dataValid cycles.
3. READ_LATENCY=3, DATA_WIDTH=16, ADDR_WIDTH=6: write 16'hBEEF to addr 63, read addr 63 -> dataValid exactly 3 edges later with 16'hBEEF; clear takes 64 cycles.
4. req=1 read during clear (cycle 5 after release): overrun=1 and ledState[2]=1; no dataValid; memory unchanged; overrun stays 1 until reset.
5. Reset asserted at clear cycle 7, released, then a write of 8'h55 to addr 3 after ready: clear reruns a full 16 cycles; a subsequent read of addr 3 returns 55 and addr 4 returns 00.
6. CLEAR_ON_RESET=0, INIT_VALUE ignored: ready=1 the first cycle after reset release; a read is issued 1 cycle before reset assertion -> no dataValid after reset; dataOut=0.
